mole_field: RTL

- Parametrised multi-mole LED field for the whack-a-mole game; successor to the single-index one-hot LED decoder.
- Holds up to MAX_ACTIVE concurrently lit moles, each with its own lifetime countdown.
- Resolves player hits, wrong presses and expiries, and keeps saturating hit/miss tallies.
- Sits between the LFSR spawn source and the board LEDs/score display.

---
 rtl/mole_field.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mole_field.sv
// mole_field: multi-mole LED field for the whack-a-mole game.
// Keeps up to MAX_ACTIVE lit moles, each with its own lifetime countdown.
// Each cycle it resolves spawn requests, player hits, wrong presses and
// expiries, and keeps saturating hit/miss tallies.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick          lifetime time-base enable (one-cycle pulse)
//   spawn_valid   request to light slot spawn_idx
//   spawn_idx     requested slot
//   hit           player press pulses, one bit per slot
//   leds          registered lit-slot map
//   active_count  popcount of leds
//   spawn_accept  registered pulse: spawn taken
//   spawn_reject  registered pulse: spawn refused
//   hit_pulse     registered pulse: at least one mole hit
//   wrong_pulse   registered pulse: press on an unlit slot
//   miss_pulse    registered pulse: at least one mole expired
//   hit_count     saturating hit tally
//   miss_count    saturating miss tally (expiries + wrong presses)
module mole_field #(
  parameter int N_LEDS     = 18,
  parameter int IDX_W      = 5,
  parameter int MAX_ACTIVE = 3,
  parameter int LIFE_W     = 4,
  parameter int LIFETIME   = 10,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              spawn_valid,
  input  logic [IDX_W-1:0]  spawn_idx,
  input  logic [N_LEDS-1:0] hit,
  output logic [N_LEDS-1:0] leds,
  output logic [IDX_W-1:0]  active_count,
  output logic              spawn_accept,
  output logic              spawn_reject,
  output logic              hit_pulse,
  output logic              wrong_pulse,
  output logic              miss_pulse,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  // 7 bits hold any popcount of up to 32 slots, and the sum of two
  // disjoint popcounts (wrong presses + expiries) as well.
  localparam int PC_W  = 7;
  localparam int SUM_W = CNT_W + PC_W;

  function automatic logic [PC_W-1:0] popcount(input logic [N_LEDS-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (|s[SUM_W-1:CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  logic [N_LEDS-1:0] active;
  logic [LIFE_W-1:0] life [N_LEDS];

  logic [N_LEDS-1:0] next_active;
  logic [LIFE_W-1:0] next_life [N_LEDS];
  logic [N_LEDS-1:0] hit_mask, wrong_mask, expire_mask;
  logic [PC_W-1:0]   cur_count;
  logic              slot_busy, in_range, accept;

  assign leds = active;

  always_comb begin
    cur_count = popcount(active);
    slot_busy = 1'b0;
    for (int unsigned i = 0; i < N_LEDS; i++)
      if (spawn_idx == IDX_W'(i)) slot_busy = active[i];
    in_range = int'(spawn_idx) < N_LEDS;
    // Occupancy limit uses the count at cycle start: slots freed this
    // cycle only become available on the next one.
    accept = spawn_valid && in_range && !slot_busy &&
             (cur_count < PC_W'(MAX_ACTIVE));

    hit_mask    = hit & active;
    wrong_mask  = hit & ~active;
    expire_mask = '0;
    next_life   = life;
    // A hit slot is excluded from expiry so a simultaneous hit wins.
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (tick && active[i] && !hit[i]) begin
        if (life[i] == LIFE_W'(1)) expire_mask[i] = 1'b1;
        else                       next_life[i]   = life[i] - LIFE_W'(1);
      end
    end

    next_active = active & ~hit_mask & ~expire_mask;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (accept && spawn_idx == IDX_W'(i)) begin
        next_active[i] = 1'b1;
        next_life[i]   = LIFE_W'(LIFETIME);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      for (int unsigned i = 0; i < N_LEDS; i++) life[i] <= '0;
      active_count <= '0;
      spawn_accept <= 1'b0;
      spawn_reject <= 1'b0;
      hit_pulse    <= 1'b0;
      wrong_pulse  <= 1'b0;
      miss_pulse   <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      active       <= next_active;
      life         <= next_life;
      active_count <= IDX_W'(popcount(next_active));
      spawn_accept <= accept;
      spawn_reject <= spawn_valid && !accept;
      hit_pulse    <= |hit_mask;
      wrong_pulse  <= |wrong_mask;
      miss_pulse   <= |expire_mask;
      hit_count    <= sat_add(hit_count, popcount(hit_mask));
      miss_count   <= sat_add(miss_count,
                              popcount(wrong_mask) + popcount(expire_mask));
    end
  end

endmodule
